// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute stage.
//   - default operand/result and register-address widths
//   - opcode encodings (OP_ADD .. OP_PASSB)
//   - execute-stage FSM state encoding (ST_IDLE, ST_MUL, ST_DONE)
package exec_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SLT   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_stage_mul.sv
// mul_shift_add: unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears counter and accumulator)
//   start     load operands and begin; must only be pulsed while idle
//   a, b      multiplicand / multiplier (DATA_W bits, unsigned)
//   done      high during the cycle whose clock edge adds the final partial product;
//             product is complete from the following cycle until the next start
//   product   2*DATA_W-bit accumulator
module mul_shift_add #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplr;
  logic [CNT_W-1:0]    cnt;
  logic                busy;

  assign done    = busy && (cnt == CNT_W'(DATA_W - 1));
  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{DATA_W{1'b0}}, a};
      mplr  <= b;
    end else if (busy) begin
      if (mplr[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage behind the 8-entry register file.
// Single-cycle ALU ops write back on the cycle after acceptance; MUL runs through a
// shift-add unit (MUL state for DATA_W cycles, then DONE) and writes back DATA_W+1
// edges after acceptance. in_ready is high only in IDLE; nothing is buffered.
// Build option: define EXEC_FLAGS_EN to build the registered zero/carry flags;
// otherwise flag_z/flag_c are tied to 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   handshake from decode (transfer when both high)
//   op, op_a, op_b      opcode and operands (rd1/rd2)
//   dest, wb_en         destination register and write-back enable
//   regwrite, wa, wd    register-file write port (one-cycle strobe)
//   flag_z, flag_c      zero and carry/borrow/overflow flags
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wb_en,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              flag_z,
  output logic              flag_c
);

  state_t state, state_nxt;

  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] product;
  logic [ADDR_W-1:0]   mul_dest;
  logic                mul_wb;

  logic [DATA_W-1:0]   alu_res_p0;
  logic                upd_p0;
  logic                wr_en_p0;
  logic [ADDR_W-1:0]   wa_p0;
  logic [DATA_W-1:0]   wd_p0;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  mul_shift_add #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    alu_res_p0 = '0;
    case (op)
      OP_ADD:   alu_res_p0 = op_a + op_b;
      OP_SUB:   alu_res_p0 = op_a - op_b;
      OP_AND:   alu_res_p0 = op_a & op_b;
      OP_OR:    alu_res_p0 = op_a | op_b;
      OP_XOR:   alu_res_p0 = op_a ^ op_b;
      OP_SLT:   alu_res_p0 = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      OP_PASSB: alu_res_p0 = op_b;
      default:  alu_res_p0 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the write-back candidate for this edge
  always_comb begin
    state_nxt = state;
    upd_p0    = 1'b0;
    wr_en_p0  = 1'b0;
    wa_p0     = wa;
    wd_p0     = wd;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_nxt = ST_MUL;
          end else begin
            upd_p0   = 1'b1;
            wr_en_p0 = wb_en && (dest != '0);
            wa_p0    = dest;
            wd_p0    = alu_res_p0;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        upd_p0    = 1'b1;
        wr_en_p0  = mul_wb && (mul_dest != '0);
        wa_p0     = mul_dest;
        wd_p0     = product[DATA_W-1:0];
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write-back registers (p1): visible to the register file the cycle after the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      regwrite <= wr_en_p0;
      if (upd_p0) begin
        wa <= wa_p0;
        wd <= wd_p0;
      end
    end
  end

  // MUL destination is captured at acceptance so decode may move on
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_dest <= dest;
      mul_wb   <= wb_en;
    end
  end

`ifdef EXEC_FLAGS_EN
  logic alu_c_p0;
  logic flag_z_q, flag_c_q;

  always_comb begin
    alu_c_p0 = 1'b0;
    case (op)
      OP_ADD:  alu_c_p0 = ({1'b0, op_a} + {1'b0, op_b}) > {1'b0, {DATA_W{1'b1}}};
      OP_SUB:  alu_c_p0 = (op_a < op_b);
      default: alu_c_p0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (upd_p0) begin
      flag_z_q <= (wd_p0 == '0);
      flag_c_q <= (state == ST_DONE) ? (|product[2*DATA_W-1:DATA_W]) : alu_c_p0;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  logic unused_prod_hi;
  assign unused_prod_hi = |product[2*DATA_W-1:DATA_W];
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and randomized stimulus for exec_stage, checked every cycle
// against a transaction-level model (plain arithmetic, countdown for MUL latency),
// plus literal expectations for the hand-worked cases.
module tb_exec_stage;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] op_a, op_b;
  logic [2:0] dest;
  logic       wb_en;
  logic       regwrite;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       flag_z, flag_c;

  exec_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .dest     (dest),
    .wb_en    (wb_en),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // model state
  bit m_ready = 1'b1;
  bit m_rw    = 1'b0;
  int m_wa    = 0;
  int m_wd    = 0;
  bit m_z     = 1'b0;
  bit m_c     = 1'b0;
  int mul_left = 0;
  int mul_prod = 0;
  int mul_dest = 0;
  bit mul_wb   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // returns result in bits [7:0], carry/borrow in bit 8
  function automatic int ref_alu(input int o, input int a, input int b);
    case (o)
      0: return a + b;
      1: return ((a - b) & 255) + ((a < b) ? 256 : 0);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a < b) ? 1 : 0;
      default: return b;
    endcase
  endfunction

  task automatic apply_wb(input int res, input bit c, input int d, input bit w);
    m_rw = w && (d != 0);
    m_wa = d;
    m_wd = res;
    m_z  = (res == 0);
    m_c  = c;
  endtask

  task automatic model_step();
    int r;
    if (rst) begin
      m_ready = 1'b1; m_rw = 1'b0; m_wa = 0; m_wd = 0;
      m_z = 1'b0; m_c = 1'b0; mul_left = 0;
    end else begin
      m_rw = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          apply_wb(mul_prod & 255, mul_prod > 255, mul_dest, mul_wb);
          m_ready = 1'b1;
        end
      end else if (m_ready && in_valid) begin
        if (int'(op) == 6) begin
          // write-back lands DATA_W+1 edges after acceptance
          mul_left = 9;
          mul_prod = int'(op_a) * int'(op_b);
          mul_dest = int'(dest);
          mul_wb   = wb_en;
          m_ready  = 1'b0;
        end else begin
          r = ref_alu(int'(op), int'(op_a), int'(op_b));
          apply_wb(r & 255, r[8], int'(dest), wb_en);
        end
      end
    end
  endtask

  task automatic compare_all();
    check("regwrite", {31'd0, regwrite}, {31'd0, m_rw});
    check("wa",       {29'd0, wa},       m_wa);
    check("wd",       {24'd0, wd},       m_wd);
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
`ifdef EXEC_FLAGS_EN
    check("flag_z", {31'd0, flag_z}, {31'd0, m_z});
    check("flag_c", {31'd0, flag_c}, {31'd0, m_c});
`else
    check("flag_z_tied", {31'd0, flag_z}, 32'd0);
    check("flag_c_tied", {31'd0, flag_c}, 32'd0);
`endif
  endtask

  task automatic cyc(input bit r, input bit v, input int o, input int a, input int b,
                     input int d, input bit w);
    rst = r; in_valid = v; op = o[2:0]; op_a = a[7:0]; op_b = b[7:0];
    dest = d[2:0]; wb_en = w;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; op_a = '0; op_b = '0; dest = '0; wb_en = 1'b0;

    cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    check("lit_reset_regwrite", {31'd0, regwrite}, 32'd0);
    check("lit_reset_wd", {24'd0, wd}, 32'd0);
    check("lit_reset_ready", {31'd0, in_ready}, 32'd1);

    // ADD 0x7F + 0x01 -> dest 3
    cyc(1'b0, 1'b1, 0, 'h7F, 'h01, 3, 1'b1);
    check("lit_add_rw", {31'd0, regwrite}, 32'd1);
    check("lit_add_wa", {29'd0, wa}, 32'd3);
    check("lit_add_wd", {24'd0, wd}, 32'h80);
`ifdef EXEC_FLAGS_EN
    check("lit_add_c", {31'd0, flag_c}, 32'd0);
    check("lit_add_z", {31'd0, flag_z}, 32'd0);
`endif

    // SUB 0x05 - 0x07 -> borrow; then AND to zero
    cyc(1'b0, 1'b1, 1, 'h05, 'h07, 2, 1'b1);
    check("lit_sub_wd", {24'd0, wd}, 32'hFE);
`ifdef EXEC_FLAGS_EN
    check("lit_sub_c", {31'd0, flag_c}, 32'd1);
`endif
    cyc(1'b0, 1'b1, 2, 'hF0, 'h0F, 1, 1'b1);
    check("lit_and_wd", {24'd0, wd}, 32'h00);
`ifdef EXEC_FLAGS_EN
    check("lit_and_z", {31'd0, flag_z}, 32'd1);
    check("lit_and_c", {31'd0, flag_c}, 32'd0);
`endif
    idle(1);
    check("lit_idle_rw", {31'd0, regwrite}, 32'd0);

    // MUL 0x0F * 0x11 with decode holding an ADD request while busy
    cyc(1'b0, 1'b1, 6, 'h0F, 'h11, 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 0, 1, 1, 5, 1'b1);
      check("lit_mul_busy", {30'd0, in_ready, regwrite}, 32'd0);
    end
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    check("lit_mul_rw", {31'd0, regwrite}, 32'd1);
    check("lit_mul_wa", {29'd0, wa}, 32'd4);
    check("lit_mul_wd", {24'd0, wd}, 32'hFF);
`ifdef EXEC_FLAGS_EN
    check("lit_mul_c", {31'd0, flag_c}, 32'd0);
`endif

    // MUL 0x10 * 0x10 -> low byte zero, high half nonzero
    cyc(1'b0, 1'b1, 6, 'h10, 'h10, 6, 1'b1);
    idle(9);
    check("lit_mul2_wd", {24'd0, wd}, 32'h00);
`ifdef EXEC_FLAGS_EN
    check("lit_mul2_z", {31'd0, flag_z}, 32'd1);
    check("lit_mul2_c", {31'd0, flag_c}, 32'd1);
`endif

    // write suppression: dest 0, then wb_en 0
    cyc(1'b0, 1'b1, 0, 1, 1, 0, 1'b1);
    check("lit_dest0_rw", {31'd0, regwrite}, 32'd0);
    check("lit_dest0_wd", {24'd0, wd}, 32'h02);
    cyc(1'b0, 1'b1, 0, 1, 1, 5, 1'b0);
    check("lit_nowb_rw", {31'd0, regwrite}, 32'd0);
    check("lit_nowb_wd", {24'd0, wd}, 32'h02);

    // reset four cycles into a MUL abandons it
    cyc(1'b0, 1'b1, 6, 'hFF, 'hFF, 7, 1'b1);
    idle(4);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    check("lit_rst_ready", {31'd0, in_ready}, 32'd1);
    idle(12);
    check("lit_rst_norw", {31'd0, regwrite}, 32'd0);

    // four back-to-back ADDs
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 0, 16 * i, 3, i + 1, 1'b1);
      check("lit_b2b_rw", {31'd0, regwrite}, 32'd1);
      check("lit_b2b_wa", {29'd0, wa}, i + 1);
      check("lit_b2b_wd", {24'd0, wd}, 16 * i + 3);
    end
    idle(1);

    // randomized traffic with occasional reset and corner operands
    for (int i = 0; i < 3000; i++) begin
      int a, b;
      a = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : 255) : int'($urandom % 256);
      b = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : 255) : int'($urandom % 256);
      cyc(($urandom % 64) == 0, ($urandom % 4) != 0, int'($urandom % 8), a, b,
          int'($urandom % 8), ($urandom % 8) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
